frame_mode_sequencer: RTL

- Control block for the frame-processing chain (gamma, white balance, gray, face stages).
- Converts debounced key presses into per-stage enable bits.
- Applies enable changes only at frame start, so no frame is processed with mixed settings.
- Sequences white-balance calibration with a bounded `balance_update` window after WB enable and optional periodic re-calibration.
- Sits between the key inputs and the frame-process chain, in the pixel clock domain.

---
 rtl/frame_ctrl_pkg.sv | 25 ++
 rtl/key_press_detect.sv | 56 +++++
 rtl/frame_mode_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/frame_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// frame_ctrl_pkg
// Shared definitions for the frame-processing control slice.
//   IDX_*     : bit positions of each stage inside the key/en/pending vectors
//   N_STAGES  : number of controllable stages
//   state_t   : white-balance calibration sequencer states
//   cal_cnt_t : calibration frame counter type
// ---------------------------------------------------------------------------
package frame_ctrl_pkg;

  localparam int N_STAGES  = 4;

  localparam int IDX_GAMMA = 0;
  localparam int IDX_WB    = 1;
  localparam int IDX_GRAY  = 2;
  localparam int IDX_FACE  = 3;

  typedef enum logic {
    IDLE,
    CAL
  } state_t;

  typedef logic [7:0] cal_cnt_t;

endpackage

// File: rtl/key_press_detect.sv
// ---------------------------------------------------------------------------
// key_press_detect
// Synchronises one raw key, debounces it and emits a single-cycle pulse when
// the accepted level rises. Releases and short bounces produce nothing.
//   clk   : pixel clock
//   rstn  : asynchronous active-low reset (key treated as released)
//   key   : raw key level, active high, asynchronous to clk
//   press : one-cycle pulse, KEY edge + TICK + 3 cycles after a clean press
// ---------------------------------------------------------------------------
module key_press_detect #(
  parameter int TICK = 500_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic key,
  output logic press
);

  localparam int CNT_W = (TICK > 1) ? $clog2(TICK) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  // The counter only runs while the synchronised sample differs from the
  // accepted level; any sample matching it restarts the count, so a level
  // is taken only after TICK consecutive agreeing samples. The press pulse
  // is taken from the registered accepted level one cycle later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync1    <= key;
      sync2    <= sync1;
      stable_d <= stable;
      press    <= stable & ~stable_d;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_mode_sequencer.sv
// ---------------------------------------------------------------------------
// frame_mode_sequencer
// Turns debounced key presses into per-stage enables that only change at a
// frame start, and sequences white-balance calibration windows.
//   clk            : pixel clock
//   rstn           : asynchronous active-low reset
//   vsync          : vertical sync, synchronous to clk, active level VS_POL
//   key[3:0]       : raw keys (0 gamma, 1 wb, 2 gray, 3 face)
//   en[3:0]        : stage enables, updated only at frame start
//   balance_update : white-balance statistics update window
//   pending[3:0]   : toggles requested but not yet applied
//   frame_cnt[15:0]: frame-start counter, wraps
//   cal_busy       : high while calibrating
// ---------------------------------------------------------------------------
module frame_mode_sequencer
  import frame_ctrl_pkg::*;
#(
  parameter int   KEY_TICK      = 500_000,
  parameter int   WB_CAL_FRAMES = 4,
  parameter int   WB_PERIOD     = 0,
  parameter logic VS_POL        = 1'b1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                vsync,
  input  logic [N_STAGES-1:0] key,
  output logic [N_STAGES-1:0] en,
  output logic                balance_update,
  output logic [N_STAGES-1:0] pending,
  output logic [15:0]         frame_cnt,
  output logic                cal_busy
);

  localparam cal_cnt_t CAL_INIT = cal_cnt_t'(WB_CAL_FRAMES);

  logic [N_STAGES-1:0] press;
  logic                vs_d;
  logic                frame_start;
  state_t              state;
  cal_cnt_t            cal_cnt;
  logic [15:0]         periodic_cnt;
  logic                periodic_hit;
  logic                wb_on_req;
  logic                wb_toggle;

  for (genvar i = 0; i < N_STAGES; i++) begin : g_key
    key_press_detect #(
      .TICK (KEY_TICK)
    ) u_key (
      .clk   (clk),
      .rstn  (rstn),
      .key   (key[i]),
      .press (press[i])
    );
  end

  // The edge detector resets to the active level so that vsync already
  // asserted when reset is released is not mistaken for a frame start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vs_d        <= VS_POL;
      frame_start <= 1'b0;
    end else begin
      vs_d        <= vsync;
      frame_start <= (vsync == VS_POL) && (vs_d != VS_POL);
    end
  end

  // Periodic re-calibration fires on the frame start that completes
  // WB_PERIOD frames with white balance enabled.
  assign periodic_hit = (WB_PERIOD > 0) &&
                        (({16'd0, periodic_cnt} + 32'd1) >= 32'(WB_PERIOD));
  assign wb_toggle    = pending[IDX_WB];
  assign wb_on_req    = wb_toggle && !en[IDX_WB];

  // Enables, pending toggles and the calibration FSM all move together on
  // frame_start so a frame never sees a mix of old and new settings. A press
  // landing on the frame_start cycle seeds the fresh pending vector.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en             <= '0;
      pending        <= '0;
      frame_cnt      <= '0;
      balance_update <= 1'b0;
      cal_busy       <= 1'b0;
      state          <= IDLE;
      cal_cnt        <= '0;
      periodic_cnt   <= '0;
    end else if (frame_start) begin
      en        <= en ^ pending;
      pending   <= press;
      frame_cnt <= frame_cnt + 16'd1;

      if (en[IDX_WB]) begin
        periodic_cnt <= periodic_hit ? 16'd0 : periodic_cnt + 16'd1;
      end else begin
        periodic_cnt <= 16'd0;
      end

      case (state)
        IDLE: begin
          if (wb_on_req || (periodic_hit && en[IDX_WB] && !wb_toggle)) begin
            state          <= CAL;
            cal_cnt        <= CAL_INIT;
            balance_update <= 1'b1;
            cal_busy       <= 1'b1;
          end
        end
        CAL: begin
          // A WB toggle here can only mean WB is being switched off.
          if (wb_toggle || cal_cnt == cal_cnt_t'(1)) begin
            state          <= IDLE;
            cal_cnt        <= '0;
            balance_update <= 1'b0;
            cal_busy       <= 1'b0;
          end else begin
            cal_cnt <= cal_cnt - cal_cnt_t'(1);
          end
        end
        default: begin
          state          <= IDLE;
          balance_update <= 1'b0;
          cal_busy       <= 1'b0;
        end
      endcase
    end else begin
      pending <= pending ^ press;
    end
  end

endmodule
